filled_tris_arbiter: RTL and testbench
======================================

FILLED_TRIS_ARBITER -- requirements
Module: filled_tris_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 4096, SHALL be the maximum number of cycles a job may spend in RUN before it is aborted.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 req0, req1  in  1 each  SHALL be the draw requests from requester 0 and requester 1.
REQ-005 tri0, tri1  in  192 each  SHALL carry {x1,y1,x2,y2,x3,y3}, each signed 32-bit, with x1 in [191:160].
REQ-006 gnt0, gnt1  out  1 each  SHALL pulse for one cycle when that requester's triangle is latched.
REQ-007 done0, done1  out  1 each  SHALL pulse for one cycle when that requester's job completes.
REQ-008 err  out  1  SHALL be valid only while a done pulse is high; 1 means the job was rejected or aborted.
REQ-009 busy  out  1  SHALL be high in every state except IDLE.
REQ-010 owner  out  1  SHALL identify the requester of the current or last job.
REQ-011 rast_tri  out  192  SHALL be the latched triangle driven to the rasterizer, in the same packing as tri0/tri1.
REQ-012 rast_reset  out  1  SHALL drive the rasterizer's reset input.
REQ-013 rast_finish  in  1  SHALL be the rasterizer's finish flag.

Function
REQ-014 The FSM SHALL have four states: IDLE, CHECK, RUN and DONE.
REQ-015 IDLE, no request: SHALL stay in IDLE.
REQ-016 IDLE, req0 or req1 high:
- SHALL pick a winner by round robin and latch its tri into rast_tri.
- SHALL set owner to the winner and go to CHECK.
- The winner's gnt SHALL be high during the CHECK cycle only.
REQ-017 Round robin:
- If both requests are high, the requester that was not the last owner SHALL win.
- The last-owner register SHALL reset to 1, so req0 wins the first tie.
REQ-018 Requests SHALL be ignored outside IDLE.
REQ-019 Requester obligation: hold req and tri stable until gnt is seen, then drop req.
REQ-020 CHECK, degenerate triangle (y1==y2==y3): SHALL go to DONE with err=1; the rasterizer SHALL NOT be started (this prevents its divide-by-zero).
REQ-021 CHECK, non-degenerate triangle: SHALL go to RUN and clear the 16-bit cycle counter.
REQ-022 RUN, rast_reset: rast_reset SHALL be 0 while in RUN and 1 in IDLE, CHECK and DONE.
REQ-023 RUN, each cycle:
- The counter SHALL increment.
- rast_tri SHALL stay constant.
REQ-024 RUN, rast_finish==1: SHALL go to DONE with err=0.
REQ-025 RUN, counter == TIMEOUT-1 with rast_finish==0: SHALL go to DONE with err=1.
REQ-026 rast_finish and timeout in the same cycle: finish SHALL take priority (err=0).
REQ-027 rast_finish outside RUN SHALL be ignored.
REQ-028 DONE:
- SHALL hold the owner's done high and err valid for exactly one cycle.
- SHALL update last-owner and go to IDLE.
REQ-029 Latency:
- req sampled in IDLE → gnt at +1 cycle → RUN entered at +2 → done one cycle after the finish/timeout edge.
- Degenerate triangle: done at +2.
REQ-030 Back-to-back: a request present in the first IDLE cycle after DONE SHALL be accepted in that cycle; no extra idle cycle is required.

Reset
REQ-031 While reset is high at a clock edge, the block SHALL apply these reset values:
- state = IDLE, busy = 0, owner = 0.
- last-owner = 1, counter = 0.
- gnt0/1 = 0, done0/1 = 0, err = 0.
- rast_reset = 1, rast_tri = 0.
REQ-032 Reset takes priority over every other event:
- Reset mid-RUN SHALL abort the job with no done pulse.
- The rasterizer SHALL be held in reset from the following cycle onward.

Verification
REQ-033 Single job: req0 with (35,40),(10,20),(30,60); rasterizer model finishes 45 cycles after rast_reset falls → gnt0 at +1, rast_reset low for 45 cycles, done0=1 with err=0, busy back to 0.
REQ-034 Tie: req0 and req1 both high from reset release → order of grants gnt0, gnt1, gnt0 on repeated ties; done pulses match owner.
REQ-035 Degenerate: req1 with all three y=25 → gnt1 at +1, done1 with err=1 at +2, rast_reset never low.
REQ-036 Timeout: TIMEOUT=16 and rast_finish tied 0 → exactly 16 RUN cycles, then done with err=1.
REQ-037 Finish/timeout race: rast_finish asserted on cycle TIMEOUT-1 → err=0.
REQ-038 Reset mid-RUN: assert reset 10 cycles into RUN → no done pulse, all outputs at their REQ-031 values next cycle, and a new req0 is served normally afterwards.

Source files
------------

// File: rtl/filled_tris_arbiter_if.sv
// Request/grant, completion and rasterizer-side signals of the triangle arbiter.
// The _i/_o suffixes are seen from the arbiter.
interface filled_tris_arbiter_if;
    logic         req0_i;
    logic         req1_i;
    logic [191:0] tri0_i;
    logic [191:0] tri1_i;
    logic         gnt0_o;
    logic         gnt1_o;
    logic         done0_o;
    logic         done1_o;
    logic         err_o;
    logic         busy_o;
    logic         owner_o;
    logic [191:0] rast_tri_o;
    logic         rast_reset_o;
    logic         rast_finish_i;

    modport slave (
        input  req0_i, req1_i, tri0_i, tri1_i, rast_finish_i,
        output gnt0_o, gnt1_o, done0_o, done1_o, err_o, busy_o, owner_o,
               rast_tri_o, rast_reset_o
    );

    modport master (
        output req0_i, req1_i, tri0_i, tri1_i, rast_finish_i,
        input  gnt0_o, gnt1_o, done0_o, done1_o, err_o, busy_o, owner_o,
               rast_tri_o, rast_reset_o
    );
endinterface

// File: rtl/filled_tris_arbiter.sv
// Round-robin arbiter feeding one triangle rasterizer from two requesters,
// with degenerate-triangle rejection and a RUN-time watchdog.
//
// state | meaning
// IDLE  | waiting for a request; rasterizer held in reset
// CHECK | triangle latched, winner's gnt high, degenerate test
// RUN   | rasterizer released, watchdog counting
// DONE  | owner's done pulse with err valid, last-owner updated
module filled_tris_arbiter #(
    parameter int unsigned TIMEOUT = 4096
) (
    input logic                  clk,
    input logic                  reset,
    filled_tris_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_owner_q, last_owner_d;
    logic         err_q, err_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [191:0] tri_q, tri_d;
    logic         winner;
    logic         degenerate;

    // On a tie the requester that did not own the previous job wins.
    assign winner     = (bus.req0_i && bus.req1_i) ? ~last_owner_q : bus.req1_i;
    // A flat triangle (all y equal) would make the rasterizer divide by zero.
    assign degenerate = (tri_q[159:128] == tri_q[95:64]) && (tri_q[95:64] == tri_q[31:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            tri_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            tri_q        <= tri_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        tri_d        = tri_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req0_i || bus.req1_i) begin
                    owner_d = winner;
                    tri_d   = winner ? bus.tri1_i : bus.tri0_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (degenerate) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 16'd1;
                // Finish wins over a watchdog expiry in the same cycle.
                if (bus.rast_finish_i) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.gnt0_o       = (state_q == S_CHECK) && !owner_q;
    assign bus.gnt1_o       = (state_q == S_CHECK) &&  owner_q;
    assign bus.done0_o      = (state_q == S_DONE)  && !owner_q;
    assign bus.done1_o      = (state_q == S_DONE)  &&  owner_q;
    assign bus.err_o        = (state_q == S_DONE)  &&  err_q;
    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.owner_o      = owner_q;
    assign bus.rast_tri_o   = tri_q;
    assign bus.rast_reset_o = (state_q != S_RUN);

endmodule

// File: tb/tb_filled_tris_arbiter.sv
// Directed bench for filled_tris_arbiter: a default-TIMEOUT instance with a
// rasterizer model and a TIMEOUT=16 instance for watchdog cases.
module tb_filled_tris_arbiter;

    typedef struct packed {
        logic owner;
        logic err;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   fin_at   = 45;
    int   mcnt     = 0;
    logic fin_t    = 1'b0;
    sb_t  sb_main[$];
    sb_t  sb_tmo[$];

    filled_tris_arbiter_if bus_m ();
    filled_tris_arbiter_if bus_t ();

    filled_tris_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m.slave)
    );

    filled_tris_arbiter #(.TIMEOUT(16)) dut_t (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_t.slave)
    );

    always #5 clk = ~clk;

    // Rasterizer model: raises finish on the fin_at-th cycle after its reset falls.
    always @(posedge clk) begin
        if (bus_m.rast_reset_o) mcnt <= 0;
        else                    mcnt <= mcnt + 1;
    end
    assign bus_m.rast_finish_i = !bus_m.rast_reset_o && (mcnt == fin_at - 1);
    assign bus_t.rast_finish_i = fin_t;

    function automatic logic [191:0] pack(input int x1, input int y1, input int x2,
                                          input int y2, input int x3, input int y3);
        return {x1, y1, x2, y2, x3, y3};
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        sb_t e;
        if (bus_m.done0_o || bus_m.done1_o) begin
            if (sb_main.size() == 0) chk_b("main_unexpected_done", 1'b1, 1'b0);
            else begin
                e = sb_main.pop_front();
                chk_b("main_done_owner", bus_m.done1_o, e.owner);
                chk_b("main_done_err", bus_m.err_o, e.err);
            end
        end
        if (bus_t.done0_o || bus_t.done1_o) begin
            if (sb_tmo.size() == 0) chk_b("tmo_unexpected_done", 1'b1, 1'b0);
            else begin
                e = sb_tmo.pop_front();
                chk_b("tmo_done_owner", bus_t.done1_o, e.owner);
                chk_b("tmo_done_err", bus_t.err_o, e.err);
            end
        end
    end

    task automatic chk_reset(input bit t, input string tag);
        if (t) begin
            chk_v({tag, "_t_vec"}, {bus_t.busy_o, bus_t.owner_o, bus_t.gnt0_o, bus_t.gnt1_o,
                  bus_t.done0_o, bus_t.done1_o, bus_t.err_o, bus_t.rast_reset_o}, 192'h01);
            chk_v({tag, "_t_tri"}, bus_t.rast_tri_o, '0);
        end else begin
            chk_v({tag, "_m_vec"}, {bus_m.busy_o, bus_m.owner_o, bus_m.gnt0_o, bus_m.gnt1_o,
                  bus_m.done0_o, bus_m.done1_o, bus_m.err_o, bus_m.rast_reset_o}, 192'h01);
            chk_v({tag, "_m_tri"}, bus_m.rast_tri_o, '0);
        end
    endtask

    // Counts negedges until any gnt is seen (bounded).
    task automatic wait_gnt(input bit t, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (t ? (bus_t.gnt0_o || bus_t.gnt1_o) : (bus_m.gnt0_o || bus_m.gnt1_o)) break;
        end
    endtask

    // Counts cycles with rast_reset low until a done pulse (bounded).
    task automatic wait_done(input bit t, input logic [191:0] tri_exp, input string tag,
                             output int low);
        bit seen = 0;
        bit tri_bad = 0;
        low = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!(t ? bus_t.rast_reset_o : bus_m.rast_reset_o)) begin
                low++;
                if ((t ? bus_t.rast_tri_o : bus_m.rast_tri_o) !== tri_exp) tri_bad = 1;
            end
            if (t ? (bus_t.done0_o || bus_t.done1_o) : (bus_m.done0_o || bus_m.done1_o)) begin
                seen = 1;
                break;
            end
        end
        chk_b({tag, "_done_seen"}, seen, 1'b1);
        chk_b({tag, "_tri_stable"}, tri_bad, 1'b0);
    endtask

    initial begin
        logic [191:0] ta, tb;
        int n, low;

        reset = 1'b1;
        bus_m.req0_i = 0; bus_m.req1_i = 0; bus_m.tri0_i = '0; bus_m.tri1_i = '0;
        bus_t.req0_i = 0; bus_t.req1_i = 0; bus_t.tri0_i = '0; bus_t.tri1_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset(0, "rst");
        chk_reset(1, "rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Single job from requester 0, finish after 45 RUN cycles.
        ta = pack(35, 40, 10, 20, 30, 60);
        bus_m.tri0_i = ta;
        bus_m.req0_i = 1;
        fin_at = 45;
        sb_main.push_back('{owner: 1'b0, err: 1'b0});
        wait_gnt(0, n);
        chk_i("single_gnt_latency", n, 2);
        chk_b("single_gnt0", bus_m.gnt0_o, 1'b1);
        chk_b("single_gnt1", bus_m.gnt1_o, 1'b0);
        chk_v("single_rast_tri", bus_m.rast_tri_o, ta);
        chk_b("single_rast_reset_check", bus_m.rast_reset_o, 1'b1);
        bus_m.req0_i = 0;
        wait_done(0, ta, "single", low);
        chk_i("single_run_cycles", low, 45);
        chk_b("single_done0", bus_m.done0_o, 1'b1);
        chk_b("single_busy_in_done", bus_m.busy_o, 1'b1);
        @(negedge clk);
        chk_b("single_done_one_cycle", bus_m.done0_o, 1'b0);
        chk_b("single_busy_idle", bus_m.busy_o, 1'b0);

        // Repeated ties from reset release: gnt0, gnt1, gnt0, back to back.
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ta = pack(1, 2, 3, 4, 5, 9);
        tb = pack(7, 0, 8, 3, 2, 6);
        bus_m.tri0_i = ta;
        bus_m.tri1_i = tb;
        bus_m.req0_i = 1;
        bus_m.req1_i = 1;
        fin_at = 5;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sb_main.push_back('{owner: (k == 1), err: 1'b0});
            wait_gnt(0, n);
            chk_i($sformatf("tie%0d_gnt_gap", k), n, 2);
            chk_b($sformatf("tie%0d_gnt1", k), bus_m.gnt1_o, (k == 1));
            chk_b($sformatf("tie%0d_owner", k), bus_m.owner_o, (k == 1));
            chk_v($sformatf("tie%0d_rast_tri", k), bus_m.rast_tri_o, (k == 1) ? tb : ta);
            if (k == 2) begin
                bus_m.req0_i = 0;
                bus_m.req1_i = 0;
            end
            wait_done(0, (k == 1) ? tb : ta, $sformatf("tie%0d", k), low);
            chk_i($sformatf("tie%0d_run_cycles", k), low, 5);
        end
        @(negedge clk);
        chk_b("tie_busy_idle", bus_m.busy_o, 1'b0);

        // Degenerate triangle from requester 1: rejected, rasterizer never released.
        tb = pack(3, 25, 9, 25, 100, 25);
        bus_m.tri1_i = tb;
        bus_m.req1_i = 1;
        sb_main.push_back('{owner: 1'b1, err: 1'b1});
        wait_gnt(0, n);
        chk_i("degen_gnt_latency", n, 1);
        chk_b("degen_gnt1", bus_m.gnt1_o, 1'b1);
        chk_b("degen_rast_reset_a", bus_m.rast_reset_o, 1'b1);
        bus_m.req1_i = 0;
        @(negedge clk);
        chk_b("degen_done1", bus_m.done1_o, 1'b1);
        chk_b("degen_err", bus_m.err_o, 1'b1);
        chk_b("degen_rast_reset_b", bus_m.rast_reset_o, 1'b1);
        @(negedge clk);
        chk_b("degen_busy_idle", bus_m.busy_o, 1'b0);

        // Reset ten cycles into RUN aborts the job silently.
        tb = pack(-5, 0, 40, 30, 10, 70);
        bus_m.tri1_i = tb;
        bus_m.req1_i = 1;
        fin_at = 45;
        wait_gnt(0, n);
        chk_b("abort_gnt1", bus_m.gnt1_o, 1'b1);
        bus_m.req1_i = 0;
        repeat (10) @(negedge clk);
        chk_b("abort_in_run", bus_m.rast_reset_o, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_reset(0, "abort");
        reset = 1'b0;
        ta = pack(35, 40, 10, 20, 30, 60);
        bus_m.tri0_i = ta;
        bus_m.req0_i = 1;
        sb_main.push_back('{owner: 1'b0, err: 1'b0});
        wait_gnt(0, n);
        chk_i("after_abort_gnt_latency", n, 1);
        chk_b("after_abort_gnt0", bus_m.gnt0_o, 1'b1);
        bus_m.req0_i = 0;
        wait_done(0, ta, "after_abort", low);
        chk_i("after_abort_run_cycles", low, 45);

        // Watchdog expiry on the TIMEOUT=16 instance.
        fin_t = 0;
        ta = pack(35, 40, 10, 20, 30, 60);
        bus_t.tri0_i = ta;
        bus_t.req0_i = 1;
        sb_tmo.push_back('{owner: 1'b0, err: 1'b1});
        wait_gnt(1, n);
        chk_b("tmo_gnt0", bus_t.gnt0_o, 1'b1);
        bus_t.req0_i = 0;
        wait_done(1, ta, "tmo", low);
        chk_i("tmo_run_cycles", low, 16);
        chk_b("tmo_err", bus_t.err_o, 1'b1);

        // Finish on the last watchdog cycle wins.
        tb = pack(0, 0, 20, 10, 5, 30);
        bus_t.tri1_i = tb;
        bus_t.req1_i = 1;
        sb_tmo.push_back('{owner: 1'b1, err: 1'b0});
        wait_gnt(1, n);
        chk_b("race_gnt1", bus_t.gnt1_o, 1'b1);
        bus_t.req1_i = 0;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus_t.rast_reset_o) begin
                low++;
                if (low == 16) fin_t = 1;
            end
            if (bus_t.done0_o || bus_t.done1_o) break;
        end
        fin_t = 0;
        chk_i("race_run_cycles", low, 16);
        chk_b("race_done1", bus_t.done1_o, 1'b1);
        chk_b("race_err", bus_t.err_o, 1'b0);

        @(negedge clk);
        chk_i("sb_main_empty", sb_main.size(), 0);
        chk_i("sb_tmo_empty", sb_tmo.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
